// File: rtl/inst_prefetch_queue_if.sv
// Memory port shared by the prefetch unit and the core's stage arbiter.
// The fetch unit is the master: it raises mem_read with an address and
// waits for the one-cycle mem_done pulse carrying the read data.
interface inst_prefetch_queue_if;
  logic        mem_grant;
  logic [63:0] mem_address;
  logic [1:0]  mem_datasize;
  logic        mem_read;
  logic [63:0] mem_readdata;
  logic        mem_done;

  modport master (
    input  mem_grant,
    input  mem_readdata,
    input  mem_done,
    output mem_address,
    output mem_datasize,
    output mem_read
  );

  modport slave (
    output mem_grant,
    output mem_readdata,
    output mem_done,
    input  mem_address,
    input  mem_datasize,
    input  mem_read
  );
endinterface

// File: rtl/inst_prefetch_queue.sv
// Prefetching instruction fetch unit for the MMIX core.
// Fetches sequential tetras into a DEPTH-entry FIFO ahead of dispatch,
// one outstanding read at a time. A redirect flushes the queue; a read
// already on the bus is allowed to finish and its data is thrown away.
module inst_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h8000_0000_0000_0000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     redirect,
  input  logic [63:0]              redirect_pc,
  input  logic                     deq,
  output logic                     head_valid,
  output logic [63:0]              head_loc,
  output logic [31:0]              head_inst,
  output logic [$clog2(DEPTH):0]   count,
  inst_prefetch_queue_if.master    mem
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_C     = PW'(DEPTH);
  localparam logic [63:0]   RESET_ALIGN = {RESET_PC[63:2], 2'b00};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t        state_reg, state_next;
  logic [63:0]   fetch_pc_reg, fetch_pc_next;
  logic          mem_read_reg, mem_read_next;
  logic [63:0]   mem_address_reg, mem_address_next;
  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic          push;
  logic          pop;
  logic          full;
  logic [63:0]   redirect_aligned;

  // Queue storage: the location and tetra of each fetched instruction.
  logic [63:0]   loc_mem  [DEPTH];
  logic [31:0]   inst_mem [DEPTH];

  // Upper data half and low redirect bits carry nothing for instruction fetch.
  logic unused_bits;
  assign unused_bits = ^{mem.mem_readdata[63:32], redirect_pc[1:0]};

  assign redirect_aligned = {redirect_pc[63:2], 2'b00};
  assign count            = wr_ptr_reg - rd_ptr_reg;
  assign full             = (count == DEPTH_C);
  assign head_valid       = (count != '0);
  assign head_loc         = loc_mem[rd_ptr_reg[AW-1:0]];
  assign head_inst        = inst_mem[rd_ptr_reg[AW-1:0]];

  assign mem.mem_read     = mem_read_reg;
  assign mem.mem_address  = mem_address_reg;
  assign mem.mem_datasize = 2'd2;

  // Next-state and bus control: issue from IDLE, wait for mem_done in REQ,
  // and swallow the in-flight read in DRAIN after a redirect.
  always_comb begin
    state_next       = state_reg;
    fetch_pc_next    = fetch_pc_reg;
    mem_read_next    = mem_read_reg;
    mem_address_next = mem_address_reg;
    push             = 1'b0;
    case (state_reg)
      IDLE: begin
        if (redirect) begin
          fetch_pc_next = redirect_aligned;
        end else if (mem.mem_grant && !full) begin
          mem_read_next    = 1'b1;
          mem_address_next = fetch_pc_reg;
          state_next       = REQ;
        end
      end
      REQ: begin
        if (redirect) begin
          fetch_pc_next = redirect_aligned;
          if (mem.mem_done) begin
            mem_read_next = 1'b0;
            state_next    = IDLE;
          end else begin
            state_next = DRAIN;
          end
        end else if (mem.mem_done) begin
          push          = 1'b1;
          fetch_pc_next = fetch_pc_reg + 64'd4;
          mem_read_next = 1'b0;
          state_next    = IDLE;
        end
      end
      DRAIN: begin
        if (redirect) begin
          fetch_pc_next = redirect_aligned;
        end
        if (mem.mem_done) begin
          mem_read_next = 1'b0;
          state_next    = IDLE;
        end
      end
      default: begin
        state_next    = IDLE;
        mem_read_next = 1'b0;
      end
    endcase
  end

  // Pointer update: a redirect empties the queue and drops any pop or push.
  always_comb begin
    pop         = deq && head_valid && !redirect;
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    if (redirect) begin
      rd_ptr_next = wr_ptr_reg;
    end else begin
      if (push) wr_ptr_next = wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_next = rd_ptr_reg + PW'(1);
    end
  end

  // State, fetch address, bus and pointer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      fetch_pc_reg    <= RESET_ALIGN;
      mem_read_reg    <= 1'b0;
      mem_address_reg <= RESET_ALIGN;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
    end else begin
      state_reg       <= state_next;
      fetch_pc_reg    <= fetch_pc_next;
      mem_read_reg    <= mem_read_next;
      mem_address_reg <= mem_address_next;
      wr_ptr_reg      <= wr_ptr_next;
      rd_ptr_reg      <= rd_ptr_next;
    end
  end

  // Queue write port; contents need no reset since the pointers gate validity.
  always_ff @(posedge clk) begin
    if (push) begin
      loc_mem[wr_ptr_reg[AW-1:0]]  <= fetch_pc_reg;
      inst_mem[wr_ptr_reg[AW-1:0]] <= mem.mem_readdata[31:0];
    end
  end

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Self-checking bench for inst_prefetch_queue: a small memory responder with
// adjustable latency, a table of expected fetches/pops, and hand-written
// sequences for redirect, same-cycle push/pop, grant drop, wrap and reset.
module tb_inst_prefetch_queue;
  localparam logic [63:0] RPC = 64'h8000_0000_0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect = 1'b0;
  logic [63:0] redirect_pc = 64'h0;
  logic        deq = 1'b0;
  logic        head_valid;
  logic [63:0] head_loc;
  logic [31:0] head_inst;
  logic [2:0]  count;

  inst_prefetch_queue_if mem();

  inst_prefetch_queue #(.DEPTH(4), .RESET_PC(RPC)) dut (
    .clk         (clk),
    .reset       (reset),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .deq         (deq),
    .head_valid  (head_valid),
    .head_loc    (head_loc),
    .head_inst   (head_inst),
    .count       (count),
    .mem         (mem)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int mem_lat = 2;
  int wait_cnt = 0;
  logic [63:0] rd_log[$];

  typedef struct {
    logic [63:0] loc;
    logic [31:0] inst;
  } vec_t;

  vec_t fetch_tab[4];
  vec_t pop_tab[4];

  function automatic logic [31:0] inst_of(input logic [63:0] a);
    return a[31:0] ^ 32'h1357_9BDF ^ {a[63:56], 24'h0};
  endfunction

  // Memory responder: counts mem_lat cycles of mem_read, then a one-cycle done.
  always @(posedge clk) begin
    #1;
    if (reset) begin
      mem.mem_done     = 1'b0;
      mem.mem_readdata = 64'h0;
      wait_cnt         = 0;
    end else if (mem.mem_done) begin
      mem.mem_done = 1'b0;
    end else if (mem.mem_read) begin
      wait_cnt++;
      if (wait_cnt >= mem_lat) begin
        mem.mem_done     = 1'b1;
        mem.mem_readdata = {32'hDEAD_BEEF, inst_of(mem.mem_address)};
        rd_log.push_back(mem.mem_address);
        wait_cnt = 0;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_read(input string name);
    int k = 0;
    while (mem.mem_read !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk(name, {63'h0, mem.mem_read}, 64'h1);
  endtask

  task automatic wait_log(input int n, input string name);
    int k = 0;
    while (rd_log.size() < n && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk(name, 64'(rd_log.size()), 64'(n));
  endtask

  task automatic pop_one();
    deq = 1'b1;
    @(negedge clk);
    deq = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      fetch_tab[i].loc  = RPC + 64'(4 * i);
      fetch_tab[i].inst = inst_of(RPC + 64'(4 * i));
      pop_tab[i].loc    = RPC + 64'(4 * (i + 1));
      pop_tab[i].inst   = inst_of(RPC + 64'(4 * (i + 1)));
    end
    mem.mem_grant = 1'b1;

    // Reset state
    cyc(2);
    chk("rst_head_valid", {63'h0, head_valid}, 64'h0);
    chk("rst_count", 64'(count), 64'h0);
    chk("rst_mem_read", {63'h0, mem.mem_read}, 64'h0);
    chk("rst_datasize", 64'(mem.mem_datasize), 64'h2);
    chk("rst_mem_address", mem.mem_address, RPC);

    // Fill from reset: first request one cycle after release
    reset = 1'b0;
    @(negedge clk);
    chk("first_req_read", {63'h0, mem.mem_read}, 64'h1);
    chk("first_req_addr", mem.mem_address, RPC);
    wait_log(4, "fill_reads");
    cyc(6);
    for (int i = 0; i < 4; i++)
      chk($sformatf("fill_addr%0d", i), rd_log[i], fetch_tab[i].loc);
    chk("full_no_read", {63'h0, mem.mem_read}, 64'h0);
    chk("full_log_size", 64'(rd_log.size()), 64'd4);
    chk("full_count", 64'(count), 64'd4);
    chk("full_head_loc", head_loc, fetch_tab[0].loc);
    chk("full_head_inst", 64'(head_inst), 64'(fetch_tab[0].inst));

    // One deq on a full queue refills exactly one entry
    pop_one();
    chk("deq_count", 64'(count), 64'd3);
    wait_log(5, "refill_read");
    cyc(6);
    chk("refill_addr", rd_log[4], RPC + 64'd16);
    chk("refill_count", 64'(count), 64'd4);
    chk("refill_log_size", 64'(rd_log.size()), 64'd5);

    // Drain in order with fetch stopped
    mem.mem_grant = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("pop%0d_valid", i), {63'h0, head_valid}, 64'h1);
      chk($sformatf("pop%0d_loc", i), head_loc, pop_tab[i].loc);
      chk($sformatf("pop%0d_inst", i), 64'(head_inst), 64'(pop_tab[i].inst));
      pop_one();
    end
    chk("empty_count", 64'(count), 64'h0);
    chk("empty_head_valid", {63'h0, head_valid}, 64'h0);
    pop_one();
    chk("deq_empty_count", 64'(count), 64'h0);
    chk("deq_empty_valid", {63'h0, head_valid}, 64'h0);

    // Redirect while a read is in flight
    mem.mem_grant = 1'b1;
    wait_log(6, "pre_redirect_read");
    mem_lat = 5;
    @(negedge clk);
    wait_read("inflight_read");
    chk("inflight_addr", mem.mem_address, RPC + 64'd24);
    chk("pre_redirect_count", 64'(count), 64'd1);
    redirect    = 1'b1;
    redirect_pc = 64'h103;
    @(negedge clk);
    redirect = 1'b0;
    mem_lat  = 2;
    chk("redir_count", 64'(count), 64'h0);
    chk("redir_head_valid", {63'h0, head_valid}, 64'h0);
    chk("redir_read_held", {63'h0, mem.mem_read}, 64'h1);
    chk("redir_addr_held", mem.mem_address, RPC + 64'd24);
    wait_log(8, "post_redirect_read");
    mem.mem_grant = 1'b0;
    cyc(3);
    chk("drained_addr", rd_log[6], RPC + 64'd24);
    chk("new_target_addr", rd_log[7], 64'h100);
    chk("redir_new_count", 64'(count), 64'd1);
    chk("redir_head_loc", head_loc, 64'h100);
    chk("redir_head_inst", 64'(head_inst), 64'(inst_of(64'h100)));

    // Push and pop in the same cycle with count=2
    mem.mem_grant = 1'b1;
    wait_log(9, "second_entry_read");
    mem.mem_grant = 1'b0;
    cyc(3);
    chk("pp_pre_count", 64'(count), 64'd2);
    mem.mem_grant = 1'b1;
    begin
      int k = 0;
      while (mem.mem_done !== 1'b1 && k < 200) begin
        @(negedge clk);
        k++;
      end
    end
    chk("pp_done_seen", {63'h0, mem.mem_done}, 64'h1);
    deq = 1'b1;
    mem.mem_grant = 1'b0;
    @(negedge clk);
    deq = 1'b0;
    chk("pp_count", 64'(count), 64'd2);
    chk("pp_head0", head_loc, 64'h104);
    pop_one();
    chk("pp_head1", head_loc, 64'h108);
    chk("pp_head1_inst", 64'(head_inst), 64'(inst_of(64'h108)));
    pop_one();
    chk("pp_end_count", 64'(count), 64'h0);

    // Grant dropped mid-request
    mem_lat = 4;
    mem.mem_grant = 1'b1;
    wait_read("nogrant_read");
    mem.mem_grant = 1'b0;
    chk("nogrant_addr", mem.mem_address, 64'h10C);
    @(negedge clk);
    chk("nogrant_read_held", {63'h0, mem.mem_read}, 64'h1);
    chk("nogrant_addr_held", mem.mem_address, 64'h10C);
    wait_log(11, "nogrant_done");
    cyc(8);
    chk("nogrant_no_issue", {63'h0, mem.mem_read}, 64'h0);
    chk("nogrant_log_size", 64'(rd_log.size()), 64'd11);
    chk("nogrant_count", 64'(count), 64'd1);
    chk("nogrant_head_loc", head_loc, 64'h10C);
    pop_one();

    // Address wrap at the top of the space
    redirect    = 1'b1;
    redirect_pc = 64'hFFFF_FFFF_FFFF_FFFE;
    @(negedge clk);
    redirect = 1'b0;
    mem_lat  = 2;
    mem.mem_grant = 1'b1;
    wait_log(13, "wrap_reads");
    mem_lat = 6;
    @(negedge clk);
    chk("wrap_addr_top", rd_log[11], 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_addr_zero", rd_log[12], 64'h0);

    // Reset in the middle of a read
    wait_read("rst_mid_read");
    chk("rst_mid_addr", mem.mem_address, 64'h4);
    chk("rst_mid_pre_count", 64'(count), 64'd2);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_mem_read", {63'h0, mem.mem_read}, 64'h0);
    chk("rst_mid_count", 64'(count), 64'h0);
    chk("rst_mid_head_valid", {63'h0, head_valid}, 64'h0);
    chk("rst_mid_address", mem.mem_address, RPC);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_restart_read", {63'h0, mem.mem_read}, 64'h1);
    chk("rst_restart_addr", mem.mem_address, RPC);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
